// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes over XLEN cycles, sign fix-up in one cycle, result held until taken.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);
    localparam int CW = $clog2(XLEN);
    localparam int PW = 2 * XLEN;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    function automatic logic [XLEN-1:0] cneg(input logic [XLEN-1:0] v, input logic n);
        return n ? (~v + XLEN'(1)) : v;
    endfunction

    function automatic logic [PW-1:0] cneg_wide(input logic [PW-1:0] v, input logic n);
        return n ? (~v + PW'(1)) : v;
    endfunction

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic            neg1_q, neg1_d, neg2_q, neg2_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;

    logic            s1_signed, s2_signed, sg1, sg2;
    logic [XLEN-1:0] mag1, mag2;
    logic            div_zero, div_ovf, spec_hit;
    logic [XLEN-1:0] spec_res;
    logic [XLEN:0]   mul_sum, div_trial, div_diff;
    logic [PW-1:0]   mul_step, div_step, prod;
    logic [XLEN-1:0] fix_res;

    // MULHU, DIVU and REMU are the only ops treating src1 as unsigned.
    assign s1_signed = !(op[0] && (op[1] || op[2]));
    assign s2_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    assign sg1  = s1_signed && src1[XLEN-1];
    assign sg2  = s2_signed && src2[XLEN-1];
    assign mag1 = cneg(src1, sg1);
    assign mag2 = cneg(src2, sg2);

    assign div_zero = (src2 == '0);
    assign div_ovf  = !op[0] && (src1 == {1'b1, {(XLEN-1){1'b0}}}) && (&src2);
    assign spec_hit = op[2] && (div_zero || div_ovf);
    assign spec_res = div_zero ? (op[1] ? src1 : '1) : (op[1] ? '0 : src1);

    // Multiply: acc = {partial high, remaining multiplier bits}, b_q = multiplicand.
    assign mul_sum  = {1'b0, acc_q[PW-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign mul_step = {mul_sum, acc_q[XLEN-1:1]};

    // Divide: acc = {partial remainder, dividend bits shifting into quotient}, b_q = divisor.
    assign div_trial = {acc_q[PW-1:XLEN], acc_q[XLEN-1]};
    assign div_diff  = div_trial - {1'b0, b_q};
    assign div_step  = div_diff[XLEN] ? {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                      : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    assign prod = cneg_wide(acc_q, neg1_q ^ neg2_q);

    always_comb begin
        case (op_q)
            3'b001, 3'b010, 3'b011: fix_res = prod[PW-1:XLEN];
            3'b100, 3'b101:         fix_res = cneg(acc_q[XLEN-1:0], neg1_q ^ neg2_q);
            3'b110, 3'b111:         fix_res = cneg(acc_q[PW-1:XLEN], neg1_q);
            default:                fix_res = prod[XLEN-1:0];
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg1_d   = neg1_q;
        neg2_d   = neg2_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;
        zero_d   = zero_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d   = op;
                    neg1_d = sg1;
                    neg2_d = sg2;
                    b_d    = op[2] ? mag2 : mag1;
                    acc_d  = {{XLEN{1'b0}}, (op[2] ? mag1 : mag2)};
                    cnt_d  = '0;
                    if (spec_hit) begin
                        result_d = spec_res;
                        zero_d   = (spec_res == '0);
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_CALC;
                    end
                end
            end
            S_CALC: begin
                acc_d = op_q[2] ? div_step : mul_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(XLEN - 1)) state_d = S_FIX;
            end
            S_FIX: begin
                result_d = fix_res;
                zero_d   = (fix_res == '0);
                state_d  = S_DONE;
            end
            default: begin
                if (out_ready) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    // Operand and accumulator registers need no reset: they are always loaded on accept.
    always_ff @(posedge clk) begin
        op_q   <= op_d;
        neg1_q <= neg1_d;
        neg2_q <= neg2_d;
        b_q    <= b_d;
        acc_q  <= acc_d;
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign result    = result_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (XLEN = 32).
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .src1     (src1),
        .src2     (src2),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .zero     (zero),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge with out_ready high; returns just after the
    // negedge following the output handshake.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int cyc;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        op = o; src1 = a; src2 = b;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        chk({tag, ".busy"}, {in_ready, busy}, 32'b01);
        while (!out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, ".latency"}, 32'(cyc), 32'(exp_lat));
        chk({tag, ".result"}, result, exp);
        chk({tag, ".zero"}, 32'(zero), 32'(exp == 32'd0));
        @(negedge clk);
        chk({tag, ".drop"}, {out_valid, in_ready}, 32'b01);
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0; in_valid = 1'b0; op = 3'd0; src1 = '0; src2 = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset.state", {in_ready, out_valid, busy, zero}, 32'b1000);
        chk("reset.result", result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("mul_100x20",   3'b000, 32'd100,        32'd20,         32'd2000,       34);
        run_op("mulhu_max",    3'b011, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE,   34);
        run_op("mulh_m1m1",    3'b001, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000000,   34);
        run_op("mulhsu_m1x2",  3'b010, 32'hFFFFFFFF,   32'h00000002,   32'hFFFFFFFF,   34);
        run_op("mul_m7x3",     3'b000, 32'hFFFFFFF9,   32'd3,          32'hFFFFFFEB,   34);
        run_op("div_m7d2",     3'b100, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   34);
        run_op("rem_m7r2",     3'b110, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   34);
        run_op("divu_30d10",   3'b101, 32'd30,         32'd10,         32'd3,          34);
        run_op("remu_15r15",   3'b111, 32'd15,         32'd15,         32'd0,          34);
        run_op("divu_by0",     3'b101, 32'd15,         32'd0,          32'hFFFFFFFF,   1);
        run_op("rem_by0",      3'b110, 32'd15,         32'd0,          32'd15,         1);
        run_op("div_ovf",      3'b100, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1);
        run_op("rem_ovf",      3'b110, 32'h80000000,   32'hFFFFFFFF,   32'd0,          1);

        // Backpressure: result held in DONE, new offer waits for the handshake.
        out_ready = 1'b0;
        in_valid = 1'b1; op = 3'b101; src1 = 32'd30; src2 = 32'd10;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("bp.latency", 32'(cyc), 32'd34);
        in_valid = 1'b1; op = 3'b000; src1 = 32'd7; src2 = 32'd6;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp.hold_valid", {out_valid, in_ready}, 32'b10);
            chk("bp.hold_result", result, 32'd3);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp.handoff", {out_valid, in_ready, busy}, 32'b010);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp.accept_late", {in_ready, busy}, 32'b01);
        cyc = 1;
        while (!out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("bp.second_latency", 32'(cyc), 32'd34);
        chk("bp.second_result", result, 32'd42);
        @(negedge clk);

        // Reset during CALC iteration 10.
        in_valid = 1'b1; op = 3'b000; src1 = 32'd100; src2 = 32'd20;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_mid.state", {in_ready, out_valid, busy}, 32'b100);
        chk("rst_mid.result", result, 32'd0);
        repeat (40) @(negedge clk);
        chk("rst_mid.no_result", {in_ready, out_valid}, 32'b10);
        run_op("divu_100d7", 3'b101, 32'd100, 32'd7, 32'd14, 34);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative, parametrised multiply/divide unit implementing the RV32M operation set. It sits beside the single-cycle `alu` in the execute stage and takes the M-extension instructions the ALU cannot. Operands are accepted through a valid/ready handshake, computed over XLEN cycles with shift-add or restoring division, and the result is held until the consumer takes it.

## Interface
- XLEN, 32: operand and result width; must be ≥ 4 and even.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operands and op are valid this cycle.
- in_ready  out  1  unit can accept an operation (high only in IDLE).
- op  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- src1  in  XLEN  rs1 operand (dividend / multiplicand).
- src2  in  XLEN  rs2 operand (divisor / multiplier).
- out_valid  out  1  result and zero are valid.
- out_ready  in  1  consumer takes the result this cycle.
- result  out  XLEN  operation result.
- zero  out  1  result == 0; meaningful only while out_valid.
- busy  out  1  high in CALC, FIX or DONE.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready = 1.
  - When in_valid is high, latch op, src1 and src2, and record the operand signs per op. Signed operands are src1 for MUL/MULH/MULHSU/DIV/REM, and src2 for MULH/DIV/REM.
  - Load operand magnitudes and clear the iteration counter, then go to CALC.
  - Special divide cases go straight to DONE instead of CALC, with the result latched:
    - Divisor == 0: DIV/DIVU give all-ones; REM/REMU give src1.
    - DIV/REM with src1 = 1 followed by XLEN-1 zeros (most negative) and src2 = all-ones: DIV gives src1; REM gives 0.
- CALC: one iteration per cycle for exactly XLEN cycles, counter 0..XLEN-1, then go to FIX.
  - Multiply: unsigned shift-add on magnitudes into a 2·XLEN accumulator.
  - Divide: restoring division on magnitudes, producing quotient and remainder.
- FIX: apply the sign correction and select the output word, then go to DONE.
  - Product is negated when the recorded signs differ.
  - MUL takes the low XLEN bits; MULH/MULHSU/MULHU take the high XLEN bits.
  - Quotient is negated when the dividend and divisor signs differ (signed ops only).
  - Remainder takes the sign of the dividend (signed ops only).
- DONE:
  - out_valid = 1; result and zero are held stable.
  - When out_ready is high, go to IDLE.
  - in_ready stays 0 in DONE, so there is no same-cycle accept on handoff.
- All arithmetic wraps modulo 2^XLEN; no overflow flag.
- Inputs other than in_valid and out_ready are ignored outside IDLE.

## Timing
- Reset (rst_n low at an edge) values: state IDLE, in_ready 1, out_valid 0, busy 0, result 0, zero 0.
- Reset has priority over every transition, including mid-CALC. The in-flight operation is discarded and no result is produced.
- Normal latency: with accept at edge E0, out_valid rises after edge E0+XLEN+1 (34 edges for XLEN = 32).
- Special-case latency: out_valid rises after E0+1.
- Throughput: at most one op per XLEN+3 cycles with out_ready tied high.
- Handshake rules:
  - The in_valid/in_ready transfer happens only when both are high at an edge.
  - out_valid stays high until the edge where out_ready is high; it drops after that edge.
  - result must not change while out_valid is high.
- busy = (state != IDLE).

## Test plan
- MUL 100 × 20 with out_ready = 1 -> result 2000, zero 0, out_valid asserted exactly 34 cycles after accept. Then MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
- MULH and MULHSU sign handling:
  - MULH 0xFFFFFFFF × 0xFFFFFFFF -> 0x00000000.
  - MULHSU 0xFFFFFFFF × 0x00000002 -> 0xFFFFFFFF.
  - MUL 0xFFFFFFF9 × 3 -> 0xFFFFFFEB.
- Signed divide:
  - DIV −7 / 2 -> 0xFFFFFFFD.
  - REM −7 % 2 -> 0xFFFFFFFF.
  - DIVU 30 / 10 -> 3.
  - REMU 15 % 15 -> 0 with zero = 1.
- Special cases, each with out_valid one cycle after accept:
  - DIVU 15 / 0 -> 0xFFFFFFFF.
  - REM 15 % 0 -> 15.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM of the same operands -> 0.
- Backpressure: hold out_ready low for 5 cycles after out_valid rises.
  - result and out_valid stay stable and in_ready stays 0.
  - A new in_valid offered during DONE is not accepted until one cycle after the out_ready handshake.
- Reset mid-operation: drop rst_n for one edge at CALC iteration 10.
  - The next cycle shows in_ready 1, out_valid 0 and result 0.
  - A fresh DIVU 100 / 7 completes normally with result 14.
